// File: rtl/sl_preceptron_pkg.sv
// Shared definitions for the perceptron weight memory slice.
//   state_t              : loader FSM encoding (ST_IDLE=0, ST_LOAD=1, ST_DONE=2)
//   DEFAULT_DEPTH        : default number of stored weight words
//   DEFAULT_WEIGHTS_WIDTH: default weight word width
package sl_preceptron_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_DEPTH         = 64;
  localparam int DEFAULT_WEIGHTS_WIDTH = 8;

endpackage

// File: rtl/sl_preceptron_wmem_array.sv
// Single-port synchronous RAM with a registered read port.
// Ports:
//   clk   : clock, rising edge
//   we    : write enable, writes wdata at addr
//   re    : read enable, captures mem[addr] into rdata (old word on a
//           simultaneous write to the same address)
//   addr  : word address
//   wdata : write data
//   rdata : registered read data, holds when re=0
// Contents are not reset.
module sl_preceptron_wmem_array #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/sl_preceptron_weight_mem.sv
// Weight memory for the perceptron MAC. A host streams a full weight set
// through the loader (load_start, then DEPTH words on load_valid/load_ready);
// the MAC reads and writes individual words while the loader is idle.
// Handshake: a load word transfers on a rising edge where load_valid and
// load_ready are both 1; load_ready is 1 only while loading, and load_data
// must be stable while load_valid is 1.
// Ports:
//   clk, rst_n                  : clock, synchronous active-low reset
//   mem_ren/mem_wen/mem_addr/mem_wdata : MAC access, read latency 1 cycle
//   mem_rdata                   : MAC read data, held when mem_ren=0
//   load_start/load_valid/load_data    : host reload stream
//   load_ready, load_done       : loader accept / one-cycle completion pulse
//   weights_loaded              : a complete weight set is stored
//   err_addr_oob                : sticky out-of-range MAC access flag
//   err_parity                  : sticky read parity error (only with
//                                 SL_PRECEPTRON_WMEM_PARITY_EN defined)
//   dbg_state                   : current loader FSM state
// Optional feature macro: SL_PRECEPTRON_WMEM_PARITY_EN adds an even-parity
// bit per stored word and the err_parity output.
module sl_preceptron_weight_mem
  import sl_preceptron_pkg::*;
#(
  parameter int WEIGHTS_WIDTH  = DEFAULT_WEIGHTS_WIDTH,
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int DEPTH          = DEFAULT_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mem_ren,
  input  logic                      mem_wen,
  input  logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic [WEIGHTS_WIDTH-1:0]  mem_wdata,
  output logic [WEIGHTS_WIDTH-1:0]  mem_rdata,
  input  logic                      load_start,
  input  logic                      load_valid,
  input  logic [WEIGHTS_WIDTH-1:0]  load_data,
  output logic                      load_ready,
  output logic                      load_done,
  output logic                      weights_loaded,
  output logic                      err_addr_oob,
`ifdef SL_PRECEPTRON_WMEM_PARITY_EN
  output logic                      err_parity,
`endif
  output logic [1:0]                dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef SL_PRECEPTRON_WMEM_PARITY_EN
  localparam int RAM_W = WEIGHTS_WIDTH + 1;
`else
  localparam int RAM_W = WEIGHTS_WIDTH;
`endif
  localparam logic [AW-1:0]           LAST_PTR  = AW'(DEPTH - 1);
  localparam logic [MEM_ADDR_WIDTH:0] DEPTH_EXT = (MEM_ADDR_WIDTH + 1)'(DEPTH);

  state_t          state, state_nx;
  logic [AW-1:0]   wr_ptr;
  logic            rd_zero;
  logic            in_range, idle, start_ok, load_fire, mac_wr, ram_re, oob_hit;
  logic            ram_we;
  logic [AW-1:0]   ram_addr;
  logic [RAM_W-1:0] ram_wdata, ram_rdata;
  logic [WEIGHTS_WIDTH-1:0] wr_word;

  assign dbg_state = state;
  assign idle      = (state == ST_IDLE);
  assign in_range  = ({1'b0, mem_addr} < DEPTH_EXT);
  assign start_ok  = idle && load_start;
  assign load_fire = load_valid && load_ready;
  // MAC accesses are only honoured while idle; during a reload the single
  // RAM port belongs to the loader.
  assign mac_wr    = idle && mem_wen && in_range;
  assign ram_re    = idle && mem_ren && in_range;
  assign oob_hit   = idle && (mem_ren || mem_wen) && !in_range;

  assign ram_we    = load_fire || mac_wr;
  assign ram_addr  = (state == ST_LOAD) ? wr_ptr : mem_addr[AW-1:0];
  assign wr_word   = (state == ST_LOAD) ? load_data : mem_wdata;
`ifdef SL_PRECEPTRON_WMEM_PARITY_EN
  assign ram_wdata = {^wr_word, wr_word};
`else
  assign ram_wdata = wr_word;
`endif

  // Reads that bypass the RAM (out of range, or not idle) return zero; the
  // flag is only updated on a read so mem_rdata holds between reads.
  assign mem_rdata = rd_zero ? '0 : ram_rdata[WEIGHTS_WIDTH-1:0];

  always_comb begin
    state_nx   = state;
    load_ready = 1'b0;
    load_done  = 1'b0;
    case (state)
      ST_IDLE: if (load_start) state_nx = ST_LOAD;
      ST_LOAD: begin
        load_ready = 1'b1;
        if (load_valid && wr_ptr == LAST_PTR) state_nx = ST_DONE;
      end
      ST_DONE: begin
        load_done = 1'b1;
        state_nx  = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      wr_ptr         <= '0;
      weights_loaded <= 1'b0;
      err_addr_oob   <= 1'b0;
      rd_zero        <= 1'b1;
    end else begin
      state <= state_nx;
      if (start_ok) wr_ptr <= '0;
      else if (load_fire) wr_ptr <= wr_ptr + 1'b1;
      if (start_ok) weights_loaded <= 1'b0;
      else if (state == ST_DONE) weights_loaded <= 1'b1;
      if (start_ok) err_addr_oob <= 1'b0;
      else if (oob_hit) err_addr_oob <= 1'b1;
      if (mem_ren) rd_zero <= !ram_re;
    end
  end

`ifdef SL_PRECEPTRON_WMEM_PARITY_EN
  logic rd_chk;
  // Stored words carry even parity, so a good word XORs to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_chk     <= 1'b0;
      err_parity <= 1'b0;
    end else begin
      rd_chk <= ram_re;
      if (start_ok) err_parity <= 1'b0;
      else if (rd_chk && (^ram_rdata)) err_parity <= 1'b1;
    end
  end
`endif

  sl_preceptron_wmem_array #(
    .WIDTH(RAM_W),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: doc/sl_preceptron_weight_mem.md
SL_PRECEPTRON_WEIGHT_MEM -- requirements
Module: sl_preceptron_weight_mem

Interface
REQ-001 SHALL have parameter WEIGHTS_WIDTH, default 8, meaning the weight word width.
REQ-002 SHALL have parameter MEM_ADDR_WIDTH, default 16, meaning the MAC-side address width.
REQ-003 SHALL have parameter DEPTH, default 64, meaning the number of weight words stored.
REQ-004 SHALL have port clk, input, 1, the clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, the reset: synchronous, active-low.
REQ-006 SHALL have port mem_ren, input, 1, the MAC read request.
REQ-007 SHALL have port mem_wen, input, 1, the MAC write request.
REQ-008 SHALL have port mem_addr, input, MEM_ADDR_WIDTH, the MAC word address.
REQ-009 SHALL have port mem_wdata, input, WEIGHTS_WIDTH, the MAC write data.
REQ-010 SHALL have port mem_rdata, output, WEIGHTS_WIDTH, the read data returned to the MAC.
REQ-011 SHALL have port load_start, input, 1, a pulse that begins a full weight reload.
REQ-012 SHALL have port load_valid, input, 1, the host weight-stream valid.
REQ-013 SHALL have port load_data, input, WEIGHTS_WIDTH, the host weight word.
REQ-014 SHALL have port load_ready, output, 1, meaning the loader accepts a word this cycle.
REQ-015 SHALL have port load_done, output, 1, a one-cycle pulse when the reload is complete.
REQ-016 SHALL have port weights_loaded, output, 1, meaning memory holds a complete weight set.
REQ-017 SHALL have port err_addr_oob, output, 1, a sticky flag for an out-of-range MAC access.

Function
REQ-018 SHALL implement FSM states ST_IDLE, ST_LOAD and ST_DONE.
REQ-019 SHALL go ST_IDLE->ST_LOAD on load_start, clear wr_ptr to 0, clear weights_loaded and clear err_addr_oob.
REQ-020 SHALL drive load_ready=1 only in ST_LOAD; a word is accepted when load_valid && load_ready.
REQ-021 SHALL, on each accepted word, write load_data at wr_ptr and increment wr_ptr.
REQ-022 SHALL, on the accepted word with wr_ptr==DEPTH-1, go to ST_DONE; no (DEPTH+1)th word is accepted.
REQ-023 SHALL, in ST_DONE, assert load_done for one cycle, set weights_loaded and return to ST_IDLE next cycle.
REQ-024 SHALL ignore load_start outside ST_IDLE.
REQ-025 SHALL, on a MAC read with mem_ren=1 at cycle N, present mem[mem_addr] on mem_rdata at cycle N+1 (1-cycle latency).
REQ-026 SHALL hold mem_rdata at its last value when mem_ren=0.
REQ-027 SHALL return 0 for a MAC read in ST_LOAD or ST_DONE, and that read is not an error.
REQ-028 SHALL perform a MAC write (mem_wen=1) only in ST_IDLE; MAC writes in other states are dropped.
REQ-029 SHALL, when mem_ren and mem_wen are both 1, perform the write; mem_rdata then returns the old word (read-before-write).
REQ-030 SHALL, for mem_addr>=DEPTH with mem_ren or mem_wen, return rdata 0, suppress the write and set err_addr_oob until the next load_start.
REQ-031 SHALL not reset memory contents.

Reset
REQ-032 SHALL, on reset, set state=ST_IDLE, wr_ptr=0, mem_rdata=0, load_ready=0, load_done=0, weights_loaded=0, err_addr_oob=0 and err_parity=0.
REQ-033 SHALL, on reset during ST_LOAD, abort the load, leave weights_loaded=0 and leave partially written words in place.

Configuration
REQ-034 SHALL, when macro SL_PRECEPTRON_WMEM_PARITY_EN is defined, store an even-parity bit per word and add output err_parity (1 bit, sticky, cleared by load_start and reset) that is set when a read word's parity mismatches.
REQ-035 SHALL, when SL_PRECEPTRON_WMEM_PARITY_EN is undefined, have no parity storage and no err_parity port.

Structure
REQ-036 SHALL take the FSM state encoding (ST_IDLE=0, ST_LOAD=1, ST_DONE=2) and the default DEPTH/WEIGHTS_WIDTH constants from shared package sl_preceptron_pkg.
REQ-037 SHALL place the storage array in sub-module sl_preceptron_wmem_array: a single-port synchronous RAM with a registered read, instantiated once.

Verification
REQ-038 SHALL cover: load_start then 64 words 0..63 with load_valid held high -> load_done pulses one cycle after the 64th word; weights_loaded=1; MAC reads of addr 5 return 5 one cycle later.
REQ-039 SHALL cover: load_valid toggling 1/0 during a load -> wr_ptr advances only on handshakes; all 64 words are correct; load_done is not pulsed early.
REQ-040 SHALL cover: mem_ren with addr 70 (DEPTH=64) -> mem_rdata=0 and err_addr_oob=1 until the next load_start.
REQ-041 SHALL cover: MAC write 0xA5 to addr 3 in ST_IDLE, then a read -> 0xA5; the same write during ST_LOAD -> dropped.
REQ-042 SHALL cover: rst_n low after 20 loaded words -> ST_IDLE, weights_loaded=0; a new load_start then 64 words completes normally.
REQ-043 SHALL cover, with SL_PRECEPTRON_WMEM_PARITY_EN defined: forcing a stored bit flip at addr 7, then reading addr 7 -> err_parity=1.
